// File: rtl/codec_serial_emulator.sv
// Codec-side model of a WM8731-style DACDAT/ADCDAT serial port.
// Controller lines are resynchronised into clk. DAC frames are deserialised
// into {left,right} words. A handshaked ADC frame is shifted out on adcdat.
`timescale 1ns/1ps
module codec_serial_emulator #(
  parameter int SAMPLE_W = 16,
  parameter int MODE     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic                  daclrc,
  input  logic                  dacdat,
  input  logic                  adclrc,
  output logic                  adcdat,
  output logic [2*SAMPLE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_err,
  input  logic [2*SAMPLE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun
);

  localparam int               CNT_W    = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W);
  localparam logic             I2S      = (MODE == 1);

  // Sync vector bit order: 0 bclk, 1 dacdat, 2 daclrc, 3 adclrc.
  // LRC stages reset high so an idle-high LRC shows no edge after reset.
  localparam logic [3:0] SYNC_RST = 4'b1100;
  // Edge vector bit order: 0 bclk, 1 daclrc, 2 adclrc.
  localparam logic [2:0] EDGE_RST = 3'b110;

  typedef enum logic [1:0] {TX_IDLE, TX_SLOT, TX_SHIFT} tx_state_t;

  logic [3:0] sync_in, sync_ff1, sync_ff2;
  logic [2:0] edge_s, edge_d, edge_r, edge_f;
  logic       bclk_r, bclk_f, dlrc_r, dlrc_f, alrc_r, alrc_f;
  logic       dacdat_s, daclrc_s;

  logic [SAMPLE_W-1:0] left_sr, right_sr;
  logic [CNT_W-1:0]    left_cnt, right_cnt;
  logic                rx_slot, rx_armed;
  logic                take_bit;
  logic [SAMPLE_W-1:0] first_bit;

  logic [2*SAMPLE_W-1:0] hold_data;
  logic [SAMPLE_W-1:0]   right_latch;
  logic [SAMPLE_W-1:0]   load_word;

  tx_state_t           tx_state, tx_state_next;
  logic [SAMPLE_W-1:0] tx_sr, tx_sr_next;
  logic [CNT_W-1:0]    tx_cnt, tx_cnt_next;
  logic                adcdat_next;

  assign sync_in  = {adclrc, daclrc, dacdat, bclk};
  assign edge_s   = {sync_ff2[3], sync_ff2[2], sync_ff2[0]};
  assign dacdat_s = sync_ff2[1];
  assign daclrc_s = sync_ff2[2];

  // Two-flop synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff1 <= SYNC_RST;
      sync_ff2 <= SYNC_RST;
      edge_d   <= EDGE_RST;
    end else begin
      sync_ff1 <= sync_in;
      sync_ff2 <= sync_ff1;
      edge_d   <= edge_s;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    assign edge_r[gi] = edge_s[gi] & ~edge_d[gi];
    assign edge_f[gi] = ~edge_s[gi] & edge_d[gi];
  end

  assign bclk_r = edge_r[0];
  assign bclk_f = edge_f[0];
  assign dlrc_r = edge_r[1];
  assign dlrc_f = edge_f[1];
  assign alrc_r = edge_r[2];
  assign alrc_f = edge_f[2];

  // In I2S mode the first bclk rise of a channel is a slot bit; a rise that
  // coincides with the LRC edge is that slot bit itself.
  assign take_bit  = bclk_r && !(I2S && (dlrc_r || dlrc_f || rx_slot));
  assign first_bit = {{(SAMPLE_W-1){1'b0}}, dacdat_s};

  // DAC receive: per-channel shift and count, publish on each left-channel start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_sr   <= '0;
      right_sr  <= '0;
      left_cnt  <= '0;
      right_cnt <= '0;
      rx_slot   <= 1'b0;
      rx_armed  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (dlrc_r && rx_armed) begin
        rx_data  <= {left_sr, right_sr};
        rx_valid <= 1'b1;
        rx_err   <= (left_cnt < CNT_FULL) || (right_cnt < CNT_FULL);
      end
      if (dlrc_f) begin
        rx_armed <= 1'b1;
      end

      if (dlrc_r || dlrc_f) begin
        rx_slot <= I2S && !bclk_r;
      end else if (bclk_r) begin
        rx_slot <= 1'b0;
      end

      if (dlrc_r) begin
        left_sr  <= take_bit ? first_bit : '0;
        left_cnt <= take_bit ? CNT_W'(1) : '0;
      end else if (take_bit && daclrc_s && (left_cnt != CNT_FULL)) begin
        left_sr  <= {left_sr[SAMPLE_W-2:0], dacdat_s};
        left_cnt <= left_cnt + CNT_W'(1);
      end

      if (dlrc_f) begin
        right_sr  <= take_bit ? first_bit : '0;
        right_cnt <= take_bit ? CNT_W'(1) : '0;
      end else if (take_bit && !daclrc_s && (right_cnt != CNT_FULL)) begin
        right_sr  <= {right_sr[SAMPLE_W-2:0], dacdat_s};
        right_cnt <= right_cnt + CNT_W'(1);
      end
    end
  end

  // Holding register and frame latch; tx_ready low means the holding register is full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data   <= '0;
      right_latch <= '0;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (alrc_r) begin
        if (!tx_ready) begin
          right_latch <= hold_data[SAMPLE_W-1:0];
          tx_ready    <= 1'b1;
        end else begin
          right_latch <= '0;
          tx_underrun <= 1'b1;
        end
      end
      // A write coinciding with an underrun load is kept for the next frame.
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        tx_ready  <= 1'b0;
      end
    end
  end

  // Left word comes straight from the holding register, right word from the latch.
  assign load_word = alrc_r ? (tx_ready ? '0 : hold_data[2*SAMPLE_W-1:SAMPLE_W])
                            : right_latch;

  // Serializer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_sr    <= '0;
      tx_cnt   <= '0;
      adcdat   <= 1'b0;
    end else begin
      tx_state <= tx_state_next;
      tx_sr    <= tx_sr_next;
      tx_cnt   <= tx_cnt_next;
      adcdat   <= adcdat_next;
    end
  end

  // Serializer next state: an LRC load takes priority over a coincident bclk fall.
  always_comb begin
    tx_state_next = tx_state;
    tx_sr_next    = tx_sr;
    tx_cnt_next   = tx_cnt;
    adcdat_next   = adcdat;
    if (alrc_r || alrc_f) begin
      tx_sr_next = load_word;
      if (I2S) begin
        tx_state_next = TX_SLOT;
        tx_cnt_next   = '0;
        adcdat_next   = 1'b0;
      end else begin
        tx_state_next = TX_SHIFT;
        tx_cnt_next   = CNT_W'(1);
        adcdat_next   = load_word[SAMPLE_W-1];
      end
    end else if (bclk_f) begin
      case (tx_state)
        TX_SLOT: begin
          tx_state_next = TX_SHIFT;
          tx_cnt_next   = CNT_W'(1);
          adcdat_next   = tx_sr[SAMPLE_W-1];
        end
        TX_SHIFT: begin
          if (tx_cnt != CNT_FULL) begin
            tx_sr_next  = {tx_sr[SAMPLE_W-2:0], 1'b0};
            tx_cnt_next = tx_cnt + CNT_W'(1);
            adcdat_next = tx_sr[SAMPLE_W-2];
          end else begin
            tx_state_next = TX_IDLE;
            tx_cnt_next   = '0;
            adcdat_next   = 1'b0;
          end
        end
        default: begin
          adcdat_next = 1'b0;
        end
      endcase
    end
  end

endmodule
